ucie_ctl_sb_tx_arbiter: RTL and testbench

Sideband transmit arbiter and packet sequencer for the D2D adapter control path. Shares the single sideband TX serializer among `NUM_REQ` requesters using round-robin arbitration. For the granted request it builds the UCIe sideband packet: 2 phases for messages without data, 4 phases for messages with data. It then issues the packet one 32-bit phase at a time, gated by the remote configuration credit. The message decode encoding is identical to the one produced by the sideband RX FSM, so a decoded value can be looped back or answered without translation.

---
 rtl/ucie_ctl_sb_pkg.sv | 48 ++++
 rtl/ucie_ctl_sb_tx_arbiter_if.sv | 23 ++
 rtl/ucie_ctl_sb_rr_arb.sv | 27 ++
 rtl/ucie_ctl_sb_tx_arbiter.sv | 132 +++++++++++++
 tb/tb_ucie_ctl_sb_tx_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ucie_ctl_sb_pkg.sv
// Shared sideband definitions: opcodes, message codes, IDs, TX FSM states and the
// decode-to-message mapping also used by the sideband RX FSM.
package ucie_ctl_sb_pkg;

  localparam logic [4:0] OPC_NODATA = 5'b10010;
  localparam logic [4:0] OPC_DATA   = 5'b11011;

  localparam logic [7:0] MSG_01 = 8'h01;
  localparam logic [7:0] MSG_03 = 8'h03;
  localparam logic [7:0] MSG_04 = 8'h04;
  localparam logic [7:0] MSG_09 = 8'h09;

  localparam logic [2:0] SRCID = 3'b001;
  localparam logic [2:0] DSTID = 3'b101;

  typedef enum logic [2:0] {IDLE, PH0, PH1, PH2, PH3, DONE, ERR} sb_tx_state_t;

  typedef struct packed {
    logic [4:0] opcode;
    logic [7:0] msgcode;
    logic [7:0] subcode;
    logic       legal;
  } sb_msg_t;

  function automatic sb_msg_t sb_decode(input logic [4:0] dec);
    sb_msg_t m;
    m.opcode  = dec[4] ? OPC_NODATA : OPC_DATA;
    case (dec[3:2])
      2'b00:   m.msgcode = MSG_01;
      2'b01:   m.msgcode = MSG_03;
      2'b10:   m.msgcode = MSG_04;
      default: m.msgcode = MSG_09;
    endcase
    m.subcode = {6'b0, dec[1:0]};
    // Data messages only exist for msgcode 01 / subcode 00.
    if (!dec[4]) begin
      m.legal = (dec[3:0] == 4'b0000);
    end else begin
      case (dec[3:2])
        2'b01, 2'b10: m.legal = dec[0];
        2'b11:        m.legal = (dec[1:0] != 2'b11);
        default:      m.legal = 1'b0;
      endcase
    end
    return m;
  endfunction

endpackage

// File: rtl/ucie_ctl_sb_tx_arbiter_if.sv
// Requester and serializer handshake bundle for the sideband TX arbiter.
interface ucie_ctl_sb_tx_arbiter_if #(parameter int NUM_REQ = 3) ();
  logic [NUM_REQ-1:0]    i_req_vld;
  logic [5*NUM_REQ-1:0]  i_req_decode;
  logic [32*NUM_REQ-1:0] i_req_data;
  logic                  i_cfg_crd;
  logic                  i_count_done;
  logic [31:0]           o_tx_word;
  logic                  o_tx_vld;
  logic [NUM_REQ-1:0]    o_req_ack;
  logic [NUM_REQ-1:0]    o_req_err;
  logic                  o_busy;

  modport slave (
    input  i_req_vld, i_req_decode, i_req_data, i_cfg_crd, i_count_done,
    output o_tx_word, o_tx_vld, o_req_ack, o_req_err, o_busy
  );

  modport master (
    output i_req_vld, i_req_decode, i_req_data, i_cfg_crd, i_count_done,
    input  o_tx_word, o_tx_vld, o_req_ack, o_req_err, o_busy
  );
endinterface

// File: rtl/ucie_ctl_sb_rr_arb.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module ucie_ctl_sb_rr_arb #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [1:0]         ptr,
  output logic               gnt_vld,
  output logic [1:0]         gnt_idx
);

  int idx;

  // Walk offsets from farthest to nearest so the nearest hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = ptr;
    idx     = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % NUM_REQ;
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = 2'(idx);
      end
    end
  end

endmodule

// File: rtl/ucie_ctl_sb_tx_arbiter.sv
// Sideband TX arbiter: round-robin grant, packet build and phase-by-phase issue
// to the serializer under remote configuration credit.
module ucie_ctl_sb_tx_arbiter
  import ucie_ctl_sb_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  ucie_ctl_sb_tx_arbiter_if.slave  bus
);

  sb_tx_state_t state, state_nxt;
  logic [1:0]   rr_ptr, gnt_idx, gnt_idx_q, g_src, ptr_inc;
  logic         gnt_vld, grant;
  logic [4:0]   dec_q, src_dec;
  logic [31:0]  data_q, src_data;
  logic [4:0]   dec_arr  [4];
  logic [31:0]  data_arr [4];
  sb_msg_t      src_msg;
  logic [31:0]  ph0, ph1_base, ph1, word_nxt;
  logic [NUM_REQ-1:0] ack_nxt, err_nxt;

  logic [31:0]        tx_word_q;
  logic               tx_vld_q, busy_q;
  logic [NUM_REQ-1:0] ack_q, err_q;

  function automatic logic calc_cp(input logic [31:0] p0, input logic [29:0] p1_lo);
    return (^p0) ^ (^p1_lo);
  endfunction

  function automatic logic calc_dp(input logic has_data, input logic [31:0] d);
    return has_data & (^d);
  endfunction

  for (genvar k = 0; k < 4; k++) begin : g_unpack
    if (k < NUM_REQ) begin : g_used
      assign dec_arr[k]  = bus.i_req_decode[5*k +: 5];
      assign data_arr[k] = bus.i_req_data[32*k +: 32];
    end else begin : g_pad
      assign dec_arr[k]  = '0;
      assign data_arr[k] = '0;
    end
  end

  ucie_ctl_sb_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr_arb (
    .req     (bus.i_req_vld),
    .ptr     (rr_ptr),
    .gnt_vld (gnt_vld),
    .gnt_idx (gnt_idx)
  );

  assign grant   = (state == IDLE) && gnt_vld && bus.i_cfg_crd;
  assign ptr_inc = (gnt_idx_q == 2'(NUM_REQ - 1)) ? 2'd0 : gnt_idx_q + 2'd1;

  // Outputs are registered off next-state, so in IDLE the words come from the
  // live granted request and afterwards from the latched copy.
  assign src_dec  = (state == IDLE) ? dec_arr[gnt_idx]  : dec_q;
  assign src_data = (state == IDLE) ? data_arr[gnt_idx] : data_q;
  assign g_src    = (state == IDLE) ? gnt_idx : gnt_idx_q;
  assign src_msg  = sb_decode(src_dec);

  assign ph0      = {SRCID, 7'b0, src_msg.msgcode, 9'b0, src_msg.opcode};
  assign ph1_base = {2'b00, 3'b000, DSTID, 16'h0000, src_msg.subcode};
  assign ph1      = {calc_dp(~src_dec[4], src_data), calc_cp(ph0, ph1_base[29:0]),
                     ph1_base[29:0]};

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (grant) state_nxt = src_msg.legal ? PH0 : ERR;
      PH0:  if (bus.i_count_done) state_nxt = PH1;
      PH1:  if (bus.i_count_done) state_nxt = dec_q[4] ? DONE : PH2;
      PH2:  if (bus.i_count_done) state_nxt = PH3;
      PH3:  if (bus.i_count_done) state_nxt = DONE;
      DONE: state_nxt = IDLE;
      ERR:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    case (state_nxt)
      PH0:     word_nxt = ph0;
      PH1:     word_nxt = ph1;
      PH2:     word_nxt = src_data;
      default: word_nxt = '0;
    endcase
    for (int k = 0; k < NUM_REQ; k++) begin
      ack_nxt[k] = (state_nxt == DONE) && (g_src == 2'(k));
      err_nxt[k] = (state_nxt == ERR)  && (g_src == 2'(k));
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      gnt_idx_q <= '0;
      tx_word_q <= '0;
      tx_vld_q  <= 1'b0;
      ack_q     <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_nxt;
      tx_word_q <= word_nxt;
      tx_vld_q  <= (state_nxt == PH0) || (state_nxt == PH1) ||
                   (state_nxt == PH2) || (state_nxt == PH3);
      ack_q     <= ack_nxt;
      err_q     <= err_nxt;
      busy_q    <= (state_nxt != IDLE);
      if (grant) gnt_idx_q <= gnt_idx;
      if ((state == DONE) || (state == ERR)) rr_ptr <= ptr_inc;
    end
  end

  // Packet contents are frozen at grant; later requester changes are ignored.
  always_ff @(posedge i_clk) begin
    if (grant) begin
      dec_q  <= dec_arr[gnt_idx];
      data_q <= data_arr[gnt_idx];
    end
  end

  assign bus.o_tx_word = tx_word_q;
  assign bus.o_tx_vld  = tx_vld_q;
  assign bus.o_req_ack = ack_q;
  assign bus.o_req_err = err_q;
  assign bus.o_busy    = busy_q;

endmodule

// File: tb/tb_ucie_ctl_sb_tx_arbiter.sv
// Randomized self-checking bench for ucie_ctl_sb_tx_arbiter against a packet/grant model.
module tb_ucie_ctl_sb_tx_arbiter;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;

  ucie_ctl_sb_tx_arbiter_if #(.NUM_REQ(N)) bus ();

  ucie_ctl_sb_tx_arbiter #(.NUM_REQ(N)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int mptr   = 0;

  logic [31:0] exp_w [4];
  logic [31:0] obs_w [$];
  int obs_ack, obs_err, unstable, first_vld;
  bit timeout;

  logic [4:0] legal_tab [8] = '{5'b00000, 5'b10101, 5'b10111, 5'b11001,
                                5'b11011, 5'b11100, 5'b11101, 5'b11110};

  // Model of one packet: words and length from the message tables; 0 if illegal.
  task automatic ref_packet(input logic [4:0] d, input logic [31:0] data, output int n);
    logic [31:0] p0, p1;
    int msg;
    bit legal;
    legal = d inside {5'b00000, 5'b10101, 5'b10111, 5'b11001,
                      5'b11011, 5'b11100, 5'b11101, 5'b11110};
    case (d[3:2])
      2'd0: msg = 1;
      2'd1: msg = 3;
      2'd2: msg = 4;
      default: msg = 9;
    endcase
    p0 = (d[4] ? 32'd18 : 32'd27) + (32'(msg) << 14) + (32'd1 << 29);
    p1 = 32'(d[1:0]) + (32'd5 << 24);
    if ((($countones(p0) + $countones(p1 & 32'h3FFF_FFFF)) % 2) == 1) p1 = p1 | 32'h4000_0000;
    if (!d[4] && ($countones(data) % 2) == 1) p1 = p1 | 32'h8000_0000;
    exp_w[0] = p0;
    exp_w[1] = p1;
    exp_w[2] = data;
    exp_w[3] = 32'h0;
    n = !legal ? 0 : (d[4] ? 2 : 4);
  endtask

  function automatic int ref_pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic set_req(input int k, input logic [4:0] d, input logic [31:0] data);
    bus.i_req_decode[5*k +: 5]  = d;
    bus.i_req_data[32*k +: 32]  = data;
    bus.i_req_vld[k]            = 1'b1;
  endtask

  // Plays the serializer: records each new word, pulses count_done after 'stall'
  // cycles in a phase, and stops on the ack/err pulse (dropping that request).
  task automatic collect(input int stall, input int drop_ph);
    int pc;
    logic [31:0] last;
    bit fin;
    obs_w.delete();
    obs_ack = -1; obs_err = -1; unstable = 0; first_vld = -1;
    pc = 0; fin = 0; last = '0;
    for (int cyc = 1; cyc <= 400 && !fin; cyc++) begin
      @(negedge clk);
      bus.i_count_done = 1'b0;
      if (bus.o_tx_vld) begin
        if (first_vld < 0) first_vld = cyc;
        if (pc == 0) begin
          obs_w.push_back(bus.o_tx_word);
          if (obs_w.size() == drop_ph + 1) begin
            bus.i_req_vld    = '0;
            bus.i_cfg_crd    = 1'b0;
            bus.i_req_decode = 15'($urandom);
            bus.i_req_data   = {$urandom, $urandom, $urandom};
          end
        end else if (bus.o_tx_word !== last) begin
          unstable++;
        end
        last = bus.o_tx_word;
        if (pc >= stall) begin
          bus.i_count_done = 1'b1;
          pc = 0;
        end else begin
          pc++;
        end
      end else if (bus.o_req_ack != '0 || bus.o_req_err != '0) begin
        for (int k = 0; k < N; k++) begin
          if (bus.o_req_ack[k]) obs_ack = k;
          if (bus.o_req_err[k]) obs_err = k;
        end
        bus.i_req_vld = bus.i_req_vld & ~(bus.o_req_ack | bus.o_req_err);
        fin = 1;
      end else begin
        bus.i_count_done = 1'($urandom_range(0, 1));
      end
    end
    bus.i_count_done = 1'b0;
    timeout = !fin;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.i_req_vld = '0; bus.i_req_decode = '0; bus.i_req_data = '0;
    bus.i_cfg_crd = 1'b0; bus.i_count_done = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_tx_word !== 32'h0) begin errors++; $display("FAIL reset_tx_word: got %h want 0", bus.o_tx_word); end
    checks++; if (bus.o_tx_vld !== 1'b0) begin errors++; $display("FAIL reset_tx_vld: got %b want 0", bus.o_tx_vld); end
    checks++; if (bus.o_req_ack !== '0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.o_req_ack); end
    checks++; if (bus.o_req_err !== '0) begin errors++; $display("FAIL reset_err: got %b want 0", bus.o_req_err); end
    checks++; if (bus.o_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", bus.o_busy); end
    rst = 1'b1;
    mptr = 0;
    @(negedge clk);
  endtask

  task automatic test_no_data();
    int n, exp;
    set_req(0, 5'b10101, $urandom);
    bus.i_cfg_crd = 1'b1;
    ref_packet(5'b10101, bus.i_req_data[31:0], n);
    exp = ref_pick(bus.i_req_vld, mptr);
    collect(0, -1);
    mptr = (exp + 1) % N;
    checks++; if (timeout || obs_ack !== exp) begin errors++; $display("FAIL nodata_ack: got %0d want %0d (timeout=%0d)", obs_ack, exp, timeout); end
    checks++; if (first_vld !== 1) begin errors++; $display("FAIL nodata_latency: got %0d want 1", first_vld); end
    checks++; if (obs_w.size() !== n) begin errors++; $display("FAIL nodata_len: got %0d want %0d", obs_w.size(), n); end
    checks++; if (obs_w.size() < 1 || obs_w[0] !== 32'h2000C012) begin errors++; $display("FAIL nodata_ph0: got %h want 2000c012", obs_w.size() > 0 ? obs_w[0] : 32'hx); end
    checks++; if (obs_w.size() < 2 || obs_w[1] !== 32'h05000001) begin errors++; $display("FAIL nodata_ph1: got %h want 05000001", obs_w.size() > 1 ? obs_w[1] : 32'hx); end
    @(negedge clk);
    checks++; if (bus.o_req_ack !== '0 || bus.o_busy !== 1'b0) begin errors++; $display("FAIL nodata_ack_width: ack %b busy %b want 0 0", bus.o_req_ack, bus.o_busy); end
  endtask

  task automatic test_with_data();
    int exp;
    logic [31:0] lit [4] = '{32'h2000401B, 32'h85000000, 32'h00000001, 32'h00000000};
    set_req(1, 5'b00000, 32'h1);
    exp = ref_pick(bus.i_req_vld, mptr);
    collect(0, -1);
    mptr = (exp + 1) % N;
    checks++; if (timeout || obs_ack !== 1) begin errors++; $display("FAIL data_ack: got %0d want 1", obs_ack); end
    checks++; if (obs_w.size() !== 4) begin errors++; $display("FAIL data_len: got %0d want 4", obs_w.size()); end
    for (int i = 0; i < 4 && i < obs_w.size(); i++) begin
      checks++; if (obs_w[i] !== lit[i]) begin errors++; $display("FAIL data_ph%0d: got %h want %h", i, obs_w[i], lit[i]); end
    end
    @(negedge clk);
  endtask

  task automatic test_round_robin();
    int n, exp;
    rst = 1'b0; @(negedge clk); rst = 1'b1; mptr = 0; @(negedge clk);
    bus.i_cfg_crd = 1'b1;
    for (int k = 0; k < N; k++) set_req(k, legal_tab[$urandom_range(0, 7)], $urandom);
    for (int r = 0; r < 4; r++) begin
      exp = ref_pick(bus.i_req_vld, mptr);
      ref_packet(bus.i_req_decode[5*exp +: 5], bus.i_req_data[32*exp +: 32], n);
      collect($urandom_range(0, 2), -1);
      mptr = (exp + 1) % N;
      checks++; if (timeout || obs_ack !== exp) begin errors++; $display("FAIL rr_grant%0d: got %0d want %0d", r, obs_ack, exp); end
      checks++; if (obs_w.size() !== n) begin errors++; $display("FAIL rr_len%0d: got %0d want %0d", r, obs_w.size(), n); end
      for (int i = 0; i < n && i < obs_w.size(); i++) begin
        checks++; if (obs_w[i] !== exp_w[i]) begin errors++; $display("FAIL rr_word%0d_%0d: got %h want %h", r, i, obs_w[i], exp_w[i]); end
      end
      if (exp >= 0) set_req(exp, legal_tab[$urandom_range(0, 7)], $urandom);
    end
    bus.i_req_vld[1] = 1'b0;
    exp = ref_pick(bus.i_req_vld, mptr);
    collect(0, -1);
    mptr = (exp + 1) % N;
    checks++; if (timeout || obs_ack !== exp) begin errors++; $display("FAIL rr_skip: got %0d want %0d", obs_ack, exp); end
    bus.i_req_vld = '0;
    @(negedge clk);
  endtask

  task automatic test_credit_and_illegal();
    int exp, bad, k;
    bus.i_cfg_crd = 1'b0;
    set_req(0, 5'b11100, $urandom);
    bad = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.o_tx_vld !== 1'b0 || bus.o_busy !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL crd_gate: got %0d active cycles want 0", bad); end
    bus.i_cfg_crd = 1'b1;
    exp = ref_pick(bus.i_req_vld, mptr);
    collect(0, -1);
    mptr = (exp + 1) % N;
    checks++; if (first_vld !== 1 || obs_ack !== exp) begin errors++; $display("FAIL crd_grant: got lat %0d ack %0d want 1 %0d", first_vld, obs_ack, exp); end
    @(negedge clk);
    k = $urandom_range(0, N - 1);
    set_req(k, 5'b00100, $urandom);
    exp = ref_pick(bus.i_req_vld, mptr);
    collect(0, -1);
    mptr = (exp + 1) % N;
    checks++; if (timeout || obs_err !== exp || obs_ack !== -1) begin errors++; $display("FAIL illegal_err: got err %0d ack %0d want %0d -1", obs_err, obs_ack, exp); end
    checks++; if (obs_w.size() !== 0) begin errors++; $display("FAIL illegal_novld: got %0d words want 0", obs_w.size()); end
    @(negedge clk);
    for (int j = 0; j < N; j++) set_req(j, 5'b10111, $urandom);
    exp = ref_pick(bus.i_req_vld, mptr);
    collect(0, -1);
    mptr = (exp + 1) % N;
    checks++; if (obs_ack !== exp) begin errors++; $display("FAIL illegal_ptr: got %0d want %0d", obs_ack, exp); end
    bus.i_req_vld = '0;
    @(negedge clk);
  endtask

  task automatic test_stall_and_drop();
    int n, exp, k;
    k = $urandom_range(0, N - 1);
    set_req(k, 5'b00000, $urandom);
    exp = ref_pick(bus.i_req_vld, mptr);
    ref_packet(5'b00000, bus.i_req_data[32*k +: 32], n);
    collect(10, -1);
    mptr = (exp + 1) % N;
    checks++; if (unstable != 0) begin errors++; $display("FAIL stall_stable: got %0d changes want 0", unstable); end
    checks++; if (obs_ack !== exp || obs_w.size() !== n) begin errors++; $display("FAIL stall_pkt: got ack %0d len %0d want %0d %0d", obs_ack, obs_w.size(), exp, n); end
    for (int i = 0; i < n && i < obs_w.size(); i++) begin
      checks++; if (obs_w[i] !== exp_w[i]) begin errors++; $display("FAIL stall_word%0d: got %h want %h", i, obs_w[i], exp_w[i]); end
    end
    @(negedge clk);
    k = $urandom_range(0, N - 1);
    set_req(k, 5'b00000, $urandom);
    exp = ref_pick(bus.i_req_vld, mptr);
    ref_packet(5'b00000, bus.i_req_data[32*k +: 32], n);
    collect(1, 2);
    mptr = (exp + 1) % N;
    checks++; if (timeout || obs_ack !== exp || obs_w.size() !== n) begin errors++; $display("FAIL drop_pkt: got ack %0d len %0d want %0d %0d", obs_ack, obs_w.size(), exp, n); end
    for (int i = 0; i < n && i < obs_w.size(); i++) begin
      checks++; if (obs_w[i] !== exp_w[i]) begin errors++; $display("FAIL drop_word%0d: got %h want %h", i, obs_w[i], exp_w[i]); end
    end
    bus.i_req_vld = '0;
    bus.i_cfg_crd = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n, exp;
    set_req(0, 5'b11101, $urandom);
    exp = ref_pick(bus.i_req_vld, mptr);
    collect(0, -1);
    mptr = (exp + 1) % N;
    @(negedge clk);
    set_req(1, 5'b00000, $urandom);
    ref_packet(5'b00000, bus.i_req_data[63:32], n);
    @(negedge clk);
    checks++; if (bus.o_tx_vld !== 1'b1) begin errors++; $display("FAIL rstmid_ph0: got vld %b want 1", bus.o_tx_vld); end
    bus.i_count_done = 1'b1;
    @(negedge clk);
    bus.i_count_done = 1'b0;
    checks++; if (bus.o_tx_word !== exp_w[1]) begin errors++; $display("FAIL rstmid_ph1: got %h want %h", bus.o_tx_word, exp_w[1]); end
    #2 rst = 1'b0;
    #1;
    checks++; if ({bus.o_tx_word, bus.o_tx_vld, bus.o_req_ack, bus.o_req_err, bus.o_busy} !== '0) begin
      errors++; $display("FAIL rstmid_async: got word %h vld %b ack %b err %b busy %b want all 0",
                         bus.o_tx_word, bus.o_tx_vld, bus.o_req_ack, bus.o_req_err, bus.o_busy);
    end
    @(negedge clk);
    bus.i_req_vld = '0;
    rst = 1'b1;
    mptr = 0;
    @(negedge clk);
    checks++; if (bus.o_busy !== 1'b0 || bus.o_tx_vld !== 1'b0) begin errors++; $display("FAIL rstmid_idle: got busy %b vld %b want 0 0", bus.o_busy, bus.o_tx_vld); end
    set_req(0, 5'b11001, $urandom);
    set_req(1, 5'b11001, $urandom);
    exp = ref_pick(bus.i_req_vld, mptr);
    collect(0, -1);
    mptr = (exp + 1) % N;
    checks++; if (obs_ack !== exp) begin errors++; $display("FAIL rstmid_ptr: got %0d want %0d", obs_ack, exp); end
    bus.i_req_vld = '0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int n, exp;
    logic [N-1:0] v;
    for (int it = 0; it < 30; it++) begin
      v = N'($urandom_range(1, (1 << N) - 1));
      for (int k = 0; k < N; k++) begin
        if (v[k]) set_req(k, ($urandom_range(0, 3) == 0) ? 5'($urandom) : legal_tab[$urandom_range(0, 7)], $urandom);
      end
      exp = ref_pick(bus.i_req_vld, mptr);
      ref_packet(bus.i_req_decode[5*exp +: 5], bus.i_req_data[32*exp +: 32], n);
      collect($urandom_range(0, 3), -1);
      mptr = (exp + 1) % N;
      checks++; if (timeout || (n > 0 ? obs_ack : obs_err) !== exp) begin
        errors++; $display("FAIL rand%0d_grant: got ack %0d err %0d want %0d (n=%0d)", it, obs_ack, obs_err, exp, n);
      end
      checks++; if (obs_w.size() !== n) begin errors++; $display("FAIL rand%0d_len: got %0d want %0d", it, obs_w.size(), n); end
      for (int i = 0; i < n && i < obs_w.size(); i++) begin
        checks++; if (obs_w[i] !== exp_w[i]) begin errors++; $display("FAIL rand%0d_word%0d: got %h want %h", it, i, obs_w[i], exp_w[i]); end
      end
      bus.i_req_vld = '0;
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_no_data();
    test_with_data();
    test_round_robin();
    test_credit_and_illegal();
    test_stall_and_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
